// File: rtl/uart_baudgen_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_baudgen_if
// Desc     : Divider/control inputs and timing strobes of uart_baudgen.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_baudgen_if #(
    parameter int DIV_BITS  = 10,
    parameter int FRAC_BITS = 4
);
    logic                 i_en;
    logic [DIV_BITS-1:0]  i_div;
    logic [FRAC_BITS-1:0] i_frac;
    logic                 i_rxsync;
    logic                 o_rxtick;
    logic                 o_txpulse;
    logic                 o_rxpulse;
    logic                 o_rxmid;

    modport master (
        output i_en, i_div, i_frac, i_rxsync,
        input  o_rxtick, o_txpulse, o_rxpulse, o_rxmid
    );

    modport slave (
        input  i_en, i_div, i_frac, i_rxsync,
        output o_rxtick, o_txpulse, o_rxpulse, o_rxmid
    );
endinterface
`default_nettype wire

// File: rtl/uart_baudgen.sv
`default_nettype none
// ============================================================================
// Module   : uart_baudgen
// Desc     : Independent TX/RX oversampling timebases with RX start-edge
//            re-alignment and a three-sample vote window. Defining
//            UART_BAUDGEN_FRAC_EN compiles in the fractional divider.
// Revision : 1.0 - initial release
// ============================================================================
module uart_baudgen #(
    parameter int DIV_BITS  = 10,
    parameter int FRAC_BITS = 4,
    parameter int OS_LOG2   = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    uart_baudgen_if.slave bus
);
    localparam int                 c_PW       = DIV_BITS + 1;
    localparam int                 c_OSR      = 1 << OS_LOG2;
    localparam int                 c_TX       = 0;
    localparam int                 c_RX       = 1;
    localparam logic [OS_LOG2-1:0] c_SUB_LAST = OS_LOG2'(c_OSR - 1);
    localparam logic [OS_LOG2-1:0] c_WIN_LO   = OS_LOG2'(c_OSR / 2 - 3);
    localparam logic [OS_LOG2-1:0] c_WIN_HI   = OS_LOG2'(c_OSR / 2 - 1);

    logic [DIV_BITS-1:0]      r_div;
    logic [1:0][c_PW-1:0]     r_presc;
    logic [1:0][OS_LOG2-1:0]  r_sub;
    logic [1:0]               w_s;
    logic [1:0]               w_clr;
    logic [1:0]               w_tick;
    logic                     w_halt;
    logic                     w_chg;
    logic                     w_frac_chg;
    logic                     r_txpulse;
    logic                     r_rxtick;
    logic                     r_rxpulse;
    logic                     r_rxmid;

`ifdef UART_BAUDGEN_FRAC_EN
    logic [FRAC_BITS-1:0]      r_frac;
    logic [1:0][FRAC_BITS-1:0] r_acc;
    logic [1:0]                r_s;
    logic [1:0][FRAC_BITS:0]   w_sum;

    always_comb begin
        w_frac_chg = (bus.i_frac != r_frac);
        for (int i = 0; i < 2; i++) begin
            w_sum[i] = {1'b0, r_acc[i]} + {1'b0, r_frac};
        end
    end

    assign w_s = r_s;

    // Carry of each accumulation stretches the following tick period by one cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_frac <= '0;
            r_acc  <= '0;
            r_s    <= '0;
        end else begin
            r_frac <= bus.i_frac;
            for (int i = 0; i < 2; i++) begin
                if (w_clr[i]) begin
                    r_acc[i] <= '0;
                    r_s[i]   <= 1'b0;
                end else if (w_tick[i]) begin
                    r_acc[i] <= w_sum[i][FRAC_BITS-1:0];
                    r_s[i]   <= w_sum[i][FRAC_BITS];
                end
            end
        end
    end
`else
    logic [FRAC_BITS-1:0] w_unused_frac;

    assign w_frac_chg    = 1'b0;
    assign w_s           = '0;
    assign w_unused_frac = bus.i_frac;
`endif

    // Compare at DIV_BITS+1 bits so a maximal divider plus carry cannot wrap.
    always_comb begin
        w_halt = !bus.i_en || (r_div == '0);
        w_chg  = (bus.i_div != r_div) || w_frac_chg;
        for (int i = 0; i < 2; i++) begin
            w_clr[i]  = w_halt || w_chg;
            w_tick[i] = (r_presc[i] == ({1'b0, r_div} + c_PW'(w_s[i])));
        end
        w_clr[c_RX] = w_clr[c_RX] || bus.i_rxsync;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_div     <= '0;
            r_presc   <= '0;
            r_sub     <= '0;
            r_txpulse <= 1'b0;
            r_rxtick  <= 1'b0;
            r_rxpulse <= 1'b0;
            r_rxmid   <= 1'b0;
        end else begin
            r_div <= bus.i_div;
            for (int i = 0; i < 2; i++) begin
                if (w_clr[i]) begin
                    r_presc[i] <= '0;
                    r_sub[i]   <= '0;
                end else if (w_tick[i]) begin
                    r_presc[i] <= '0;
                    r_sub[i]   <= r_sub[i] + OS_LOG2'(1);
                end else begin
                    r_presc[i] <= r_presc[i] + c_PW'(1);
                end
            end
            // A clear (including rxsync) swallows a coincident tick entirely.
            r_txpulse <= !w_clr[c_TX] && w_tick[c_TX] && (r_sub[c_TX] == c_SUB_LAST);
            r_rxtick  <= !w_clr[c_RX] && w_tick[c_RX];
            r_rxpulse <= !w_clr[c_RX] && w_tick[c_RX] &&
                         (r_sub[c_RX] >= c_WIN_LO) && (r_sub[c_RX] <= c_WIN_HI);
            r_rxmid   <= !w_clr[c_RX] && w_tick[c_RX] && (r_sub[c_RX] == c_WIN_HI);
        end
    end

    assign bus.o_txpulse = r_txpulse;
    assign bus.o_rxtick  = r_rxtick;
    assign bus.o_rxpulse = r_rxpulse;
    assign bus.o_rxmid   = r_rxmid;

endmodule
`default_nettype wire

// File: tb/tb_uart_baudgen.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_baudgen
// Desc     : Self-checking bench for uart_baudgen against a closed-form model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_baudgen;
    localparam int DB  = 10;
    localparam int FB  = 4;
    localparam int OSL = 4;
    localparam int OSR = 1 << OSL;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   nprint = 0;
    int   cyc = 0;

    uart_baudgen_if #(.DIV_BITS(DB), .FRAC_BITS(FB)) bus ();

    uart_baudgen #(.DIV_BITS(DB), .FRAC_BITS(FB), .OS_LOG2(OSL)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (nprint < 40) begin
                nprint++;
                $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
            end
        end
    endtask

    // Tick n (1-based) after a clear lands n*(D+1) + floor((n-1)*F/2^FB) edges later.
    function automatic int tick_edge(int n, int d, int f);
        return n * (d + 1) + (((n - 1) * f) >> FB);
    endfunction

    bit e_tx, e_rt, e_rp, e_rm;

    initial begin : p_model
        int  m_div, m_frac, f;
        int  age[2], nt[2], sub[2];
        bit  halt, chg, fire[2];
        m_div = 0; m_frac = 0;
        for (int t = 0; t < 2; t++) begin age[t] = 0; nt[t] = 0; end
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_div = 0; m_frac = 0;
                for (int t = 0; t < 2; t++) begin age[t] = 0; nt[t] = 0; end
                e_tx = 0; e_rt = 0; e_rp = 0; e_rm = 0;
            end else begin
                halt = !bus.i_en || (m_div == 0);
                chg  = (int'(bus.i_div) != m_div);
`ifdef UART_BAUDGEN_FRAC_EN
                chg  = chg || (int'(bus.i_frac) != m_frac);
                f    = m_frac;
`else
                f    = 0;
`endif
                for (int t = 0; t < 2; t++) begin
                    fire[t] = 0;
                    sub[t]  = 0;
                    if (halt || chg || (t == 1 && bus.i_rxsync === 1'b1)) begin
                        age[t] = 0;
                        nt[t]  = 0;
                    end else begin
                        age[t]++;
                        if (age[t] == tick_edge(nt[t] + 1, m_div, f)) begin
                            fire[t] = 1;
                            sub[t]  = nt[t] % OSR;
                            nt[t]++;
                        end
                    end
                end
                e_tx = fire[0] && (sub[0] == OSR - 1);
                e_rt = fire[1];
                e_rp = fire[1] && (sub[1] >= OSR / 2 - 3) && (sub[1] <= OSR / 2 - 1);
                e_rm = fire[1] && (sub[1] == OSR / 2 - 1);
                m_div  = int'(bus.i_div);
                m_frac = int'(bus.i_frac);
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            cmp("o_txpulse", 32'(bus.o_txpulse), 32'(e_tx));
            cmp("o_rxtick",  32'(bus.o_rxtick),  32'(e_rt));
            cmp("o_rxpulse", 32'(bus.o_rxpulse), 32'(e_rp));
            cmp("o_rxmid",   32'(bus.o_rxmid),   32'(e_rm));
        end
    end

    // Event logs: 0 rxtick, 1 txpulse, 2 rxpulse, 3 rxmid (edge numbers).
    int q_rt[$], q_tx[$], q_rp[$], q_rm[$];

    initial forever begin
        @(negedge clk);
        if (bus.o_rxtick === 1'b1)  q_rt.push_back(cyc);
        if (bus.o_txpulse === 1'b1) q_tx.push_back(cyc);
        if (bus.o_rxpulse === 1'b1) q_rp.push_back(cyc);
        if (bus.o_rxmid === 1'b1)   q_rm.push_back(cyc);
    end

    function automatic int qsz(int w);
        case (w)
            0: return q_rt.size();
            1: return q_tx.size();
            2: return q_rp.size();
            default: return q_rm.size();
        endcase
    endfunction

    function automatic int qat(int w, int i);
        case (w)
            0: return q_rt[i];
            1: return q_tx[i];
            2: return q_rp[i];
            default: return q_rm[i];
        endcase
    endfunction

    function automatic int nth_from(int w, int from, int idx);
        int c = 0;
        for (int i = 0; i < qsz(w); i++) begin
            if (qat(w, i) >= from) begin
                if (c == idx) return qat(w, i);
                c++;
            end
        end
        return -1;
    endfunction

    function automatic int count_in(int lo, int hi);
        int c = 0;
        for (int w = 0; w < 4; w++)
            for (int i = 0; i < qsz(w); i++)
                if (qat(w, i) >= lo && qat(w, i) <= hi) c++;
        return c;
    endfunction

    task automatic find_evt(input int w, input int from, input int idx, input int budget,
                            output int t);
        t = nth_from(w, from, idx);
        while (t < 0 && cyc <= from + budget) begin
            @(negedge clk);
            #1;
            t = nth_from(w, from, idx);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin : p_main
        int c, k, p, s, t0, t1, t2, r;
        int tf[17];
        bit seen;

        bus.i_en = 1'b0; bus.i_div = '0; bus.i_frac = '0; bus.i_rxsync = 1'b0;
        #1 rst = 1'b1;
        #20;
        cmp("reset_outputs", 32'({bus.o_txpulse, bus.o_rxtick, bus.o_rxpulse, bus.o_rxmid}), 32'd0);

        cmp("model_edge_d9",   32'(tick_edge(1, 9, 0)), 32'd10);
        cmp("model_edge_frac", 32'(tick_edge(3, 3, 8)), 32'd13);
        cmp("model_span_frac", 32'(tick_edge(17, 3, 8) - tick_edge(1, 3, 8)), 32'd72);

        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        // D=9: ticks every 10, TX every 160.
        @(posedge clk); #2;
        bus.i_div = DB'(9); bus.i_en = 1'b1;
        c = cyc + 1;
        find_evt(0, c, 0, 30, t0);  cmp("rxtick_first", 32'(t0 - c), 32'd10);
        find_evt(0, c, 1, 40, t1);  cmp("rxtick_gap", 32'(t1 - t0), 32'd10);
        find_evt(1, c, 0, 200, t0); cmp("txpulse_first", 32'(t0 - c), 32'd160);
        find_evt(1, c, 1, 400, t1); cmp("txpulse_gap", 32'(t1 - t0), 32'd160);

        // RX re-alignment.
        @(posedge clk); #2;
        bus.i_rxsync = 1'b1;
        k = cyc + 1;
        @(posedge clk); #2;
        bus.i_rxsync = 1'b0;
        find_evt(2, k, 0, 120, t0); cmp("rxpulse_0", 32'(t0 - k), 32'd60);
        find_evt(2, k, 1, 120, t1); cmp("rxpulse_1", 32'(t1 - k), 32'd70);
        find_evt(2, k, 2, 120, t2); cmp("rxpulse_2", 32'(t2 - k), 32'd80);
        find_evt(3, k, 0, 120, t0); cmp("rxmid", 32'(t0 - k), 32'd80);
        find_evt(1, k, 0, 200, t0);
        find_evt(1, k, 1, 400, t1); cmp("tx_gap_after_sync", 32'(t1 - t0), 32'd160);

        // Divider change 9 -> 4, then rxsync on the tick at subcounter OSR/2-1.
        @(posedge clk); #2;
        bus.i_div = DB'(4);
        c = cyc + 1;
        find_evt(0, c, 0, 20, t0); cmp("rxtick_after_chg", 32'(t0 - c), 32'd5);
        while (cyc < c + 39) begin @(posedge clk); #1; end
        #1 bus.i_rxsync = 1'b1;
        @(posedge clk); #2;
        bus.i_rxsync = 1'b0;
        find_evt(0, c + 40, 0, 20, t0);  cmp("rxtick_swallowed", 32'(t0 - c), 32'd45);
        find_evt(2, c + 36, 0, 80, t0);  cmp("rxpulse_restart", 32'(t0 - c), 32'd70);
        find_evt(3, c, 0, 100, t0);      cmp("rxmid_restart", 32'(t0 - c), 32'd80);
        find_evt(1, c, 0, 100, t0);      cmp("tx_after_chg", 32'(t0 - c), 32'd80);

        // Enable dropped for 20 cycles.
        @(posedge clk); #2;
        bus.i_en = 1'b0;
        s = cyc + 1;
        repeat (20) @(posedge clk);
        #2 p = cyc;
        bus.i_en = 1'b1;
        find_evt(0, p, 0, 20, t0);
        cmp("rxtick_after_en", 32'(t0 - p), 32'd5);
        cmp("quiet_while_disabled", 32'(count_in(s, p)), 32'd0);

        // Zero divider; restoring it is itself a divider change, clearing edge p+1.
        @(posedge clk); #2;
        bus.i_div = '0;
        s = cyc + 1;
        repeat (30) @(posedge clk);
        #2 p = cyc;
        bus.i_div = DB'(4);
        find_evt(0, p, 0, 20, t0);
        cmp("rxtick_after_div0", 32'(t0 - p), 32'd6);
        cmp("quiet_div0", 32'(count_in(s, p + 1)), 32'd0);

        // Maximal divider.
        @(posedge clk); #2;
        bus.i_div = DB'((1 << DB) - 1); bus.i_frac = FB'(15);
        c = cyc + 1;
        find_evt(0, c, 0, 1100, t0); cmp("dmax_first", 32'(t0 - c), 32'd1024);
        find_evt(0, c, 1, 2200, t1); cmp("dmax_gap", 32'(t1 - t0), 32'd1024);
`ifdef UART_BAUDGEN_FRAC_EN
        find_evt(0, c, 2, 3300, t2); cmp("dmax_carry_gap", 32'(t2 - t1), 32'd1025);

        // Fractional divider D=3, F=8.
        @(posedge clk); #2;
        bus.i_div = DB'(3); bus.i_frac = FB'(8);
        c = cyc + 1;
        for (int i = 0; i < 17; i++) find_evt(0, c, i, 120, tf[i]);
        cmp("frac_first", 32'(tf[0] - c), 32'd4);
        cmp("frac_gap1", 32'(tf[1] - tf[0]), 32'd4);
        cmp("frac_gap2", 32'(tf[2] - tf[1]), 32'd5);
        cmp("frac_gap3", 32'(tf[3] - tf[2]), 32'd4);
        cmp("frac_span16", 32'(tf[16] - tf[0]), 32'd72);
`endif

        // Randomised traffic, checked cycle by cycle against the model.
        @(posedge clk); #2;
        bus.i_div = DB'(3); bus.i_frac = FB'(5); bus.i_en = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            @(posedge clk); #2;
            bus.i_rxsync = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 499) == 0) bus.i_div = DB'($urandom_range(0, 12));
            if ($urandom_range(0, 399) == 0) bus.i_frac = FB'($urandom_range(0, 15));
            if (bus.i_en && $urandom_range(0, 599) == 0) bus.i_en = 1'b0;
            else if (!bus.i_en && $urandom_range(0, 29) == 0) bus.i_en = 1'b1;
            if (bus.i_div == '0 && $urandom_range(0, 49) == 0) bus.i_div = DB'(2);
        end

        // Reset while an output is high.
        @(posedge clk); #2;
        bus.i_rxsync = 1'b0; bus.i_en = 1'b1; bus.i_div = DB'(4);
        seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (bus.o_rxtick === 1'b1) seen = 1;
        end
        cmp("tick_before_reset", 32'(seen), 32'd1);
        #1 rst = 1'b1;
        #1 cmp("async_reset_outputs",
               32'({bus.o_txpulse, bus.o_rxtick, bus.o_rxpulse, bus.o_rxmid}), 32'd0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        r = cyc + 1;
        find_evt(0, r, 0, 20, t0);
        cmp("rxtick_after_reset", 32'(t0 - r), 32'd5);
        repeat (20) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/uart_baudgen.md
# uart_baudgen

Parametrised baud-rate generator for the UART core, producing independent TX and RX timing from one system clock. The oversampling ratio, divider width and an optional fractional divider are configurable. The RX timebase re-aligns to start-bit edges and emits a three-sample majority window plus a vote-ready strobe. It sits between the register block (divider values) and the `uart_tx` / `uart_rx` shifters.

## Interface
- `DIV_BITS`, 10: integer divider width.
- `FRAC_BITS`, 4: fractional accumulator width; legal range 1..8.
- `OS_LOG2`, 4: log2 of the oversampling ratio OSR; legal range 3..6, so OSR is 8..64.

- `i_clk` in 1: system clock.
- `i_rst` in 1: asynchronous, active-high reset.
- `i_en` in 1: generator enable.
- `i_div` in DIV_BITS: integer divider D; the tick period is D+1 cycles.
- `i_frac` in FRAC_BITS: fractional divider F; adds F/2^FRAC_BITS cycles per tick on average.
- `i_rxsync` in 1: start-edge re-alignment pulse from `uart_rx`.
- `o_rxtick` out 1: RX oversample tick, one cycle wide.
- `o_txpulse` out 1: TX bit strobe, once per OSR TX ticks.
- `o_rxpulse` out 1: RX sample strobe, three per bit.
- `o_rxmid` out 1: vote-ready strobe, coincident with the third `o_rxpulse`.

## Operation
- Registered inputs: `i_div` and `i_frac` are captured into r_div and r_frac every cycle.
- Two identical timebases, TX and RX. Each contains:
  - a prescaler (DIV_BITS+1 bits);
  - a subcounter (OS_LOG2 bits, wraps OSR-1 → 0);
  - a fractional accumulator (FRAC_BITS bits).
- Tick:
  - A tick occurs when the prescaler equals the terminal value T = r_div + s.
  - On a tick: prescaler → 0, subcounter +1 (wraps), accumulator → (acc + r_frac) mod 2^FRAC_BITS.
  - s is the carry out of that addition, registered and applied to the *next* period's terminal value.
- TX: `o_txpulse` fires on the TX tick where the TX subcounter equals OSR-1.
- RX outputs:
  - `o_rxtick` fires on every RX tick.
  - `o_rxpulse` fires on RX ticks with subcounter in OSR/2-3 .. OSR/2-1.
  - `o_rxmid` fires on the RX tick with subcounter OSR/2-1.
- Halt: when `i_en`=0 or r_div=0, all prescalers, subcounters, accumulators and carry flags are held at 0 and no outputs fire.
- Divider change: if r_div or r_frac differs from the newly captured value, both timebases clear as in halt, for one cycle only.
- `i_rxsync`: clears the RX prescaler, subcounter, accumulator and carry that cycle.
  - It overrides a coincident RX tick; that tick produces no outputs.
  - The TX timebase is unaffected.
- Arithmetic: the prescaler compare is at DIV_BITS+1 bits, so D = 2^DIV_BITS-1 with s=1 does not wrap.

## Timing
- Reset value: all outputs 0; all internal state 0.
- All outputs are registered and high for exactly one cycle. They are asserted in the cycle after the edge on which the prescaler equals T.
- With F=0, the tick period is exactly D+1 cycles. With F≠0, over 2^FRAC_BITS ticks the total is 2^FRAC_BITS·(D+1)+F cycles.
- TX: `o_txpulse` period is OSR·(D+1) cycles at F=0. After release from halt at edge k, the first TX pulse rises after edge k+OSR·(D+1).
- RX: `i_rxsync` sampled at edge k gives `o_rxpulse` after edges k+(OSR/2-2)(D+1), k+(OSR/2-1)(D+1) and k+(OSR/2)(D+1). `o_rxmid` accompanies the last of these. This assumes F=0.
- Reset mid-bit: outputs drop immediately and asynchronously. There is no pending pulse after release.

## Configuration
- `UART_BAUDGEN_FRAC_EN` defined: the fractional accumulators and carry logic are compiled in, and `i_frac` behaves as above.
- Not defined: the accumulators are removed and s is constant 0.
  - `i_frac` is ignored; the port remains.
  - Changes to `i_frac` do not trigger the divider-change clear.

## Test plan
- Reset, then D=9, F=0, OSR=16, `i_en`=1 → `o_rxtick` every 10 cycles; `o_txpulse` every 160 cycles; no X on any output.
- `i_rxsync` at edge k, D=9 → `o_rxpulse` after k+60, k+70, k+80; `o_rxmid` only at k+80; TX pulse spacing unchanged.
- Macro defined, D=3, F=8, FRAC_BITS=4 → tick periods alternate 4,5,4,5; 16 ticks span 72 cycles.
- D changed 9→4 mid-bit → one-cycle clear; next `o_rxtick` 5 cycles after the clear cycle; `o_txpulse` 80 cycles after it.
- `i_div`=0, or `i_en` dropped for 20 cycles → no output pulses; on restore, first tick D+1 cycles after release.
- `i_rxsync` coincident with an RX tick at subcounter OSR/2-1 → no `o_rxpulse` or `o_rxmid` that cycle; the window restarts per the RX timing above.
